// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-port round-robin transmit scheduler for the UART byte sender
// One frame per grant: LOAD captures the byte, SEND holds tx_en low, GAP idles the line.
module uart_tx_sched #(
   parameter int unsigned FRAME_CYCLES = 11,
   parameter int unsigned GAP_CYCLES   = 1
) (
   input  logic       send_clk,
   input  logic       rst_n,
   input  logic       req0_i,
   input  logic [7:0] data0_i,
   output logic       ack0_o,
   input  logic       req1_i,
   input  logic [7:0] data1_i,
   output logic       ack1_o,
   output logic [7:0] tx_data_o,
   output logic       tx_en_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       done_src_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      GAP  = 2'd3
   } state_e;

   localparam logic [3:0] FRAME_LAST = 4'(FRAME_CYCLES - 1);
   localparam logic [3:0] GAP_LAST   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       grant_q, grant_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_en_q;

   always_ff @(posedge send_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         tx_data_q    <= 8'h00;
         tx_en_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         tx_data_q    <= tx_data_d;
         // Registered so the sender's async hold input never sees a decode glitch
         tx_en_q      <= (state_d != SEND);
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      tx_data_d    = tx_data_q;
      ack0_o       = 1'b0;
      ack1_o       = 1'b0;
      done_o       = 1'b0;
      done_src_o   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_i || req1_i) begin
               state_d = LOAD;
               grant_d = (req0_i && req1_i) ? ~last_grant_q : req1_i;
            end
         end
         LOAD: begin
            tx_data_d    = grant_q ? data1_i : data0_i;
            ack0_o       = ~grant_q;
            ack1_o       = grant_q;
            last_grant_d = grant_q;
            cnt_d        = 4'd0;
            state_d      = SEND;
         end
         SEND: begin
            if (cnt_q == FRAME_LAST) begin
               done_o     = 1'b1;
               done_src_o = grant_q;
               cnt_d      = 4'd0;
               state_d    = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 4'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_data_o = tx_data_q;
   assign tx_en_o   = tx_en_q;
   assign busy_o    = (state_q != IDLE);

endmodule
